// File: rtl/spi_shift_ctrl.sv
// spi_shift_ctrl: transfer controller placed in front of spi_clk_gen.
// Takes a parallel word over valid/ready, requests SCK via go/last_clk, and
// shifts MOSI out / samples MISO in on the generator's pos_edge/neg_edge
// strobes for any CPOL/CPHA mode, MSB- or LSB-first, 1..C_DATA_WIDTH bits.
//
// Ports:
//   sysclk, rst_n            clock, synchronous active-low reset
//   enable                   block enable; low aborts any transfer
//   CPOL, CPHA, lsb_first    mode configuration, latched at accept
//   char_len                 bits per transfer minus 1, latched at accept
//   tx_data/tx_valid/tx_ready  transmit word handshake
//   pos_edge, neg_edge       one-cycle SCK edge strobes from the clock generator
//   go, last_clk             run request / final bit indication to the generator
//   mosi, miso               serial data out / in
//   rx_data, rx_valid        received word with one-cycle valid pulse
//   busy                     transfer in progress
module spi_shift_ctrl #(
  parameter int C_DATA_WIDTH = 32,
  parameter int C_LEN_WIDTH  = 5
) (
  input  logic                    sysclk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic                    CPOL,
  input  logic                    CPHA,
  input  logic                    lsb_first,
  input  logic [C_LEN_WIDTH-1:0]  char_len,
  input  logic [C_DATA_WIDTH-1:0] tx_data,
  input  logic                    tx_valid,
  output logic                    tx_ready,
  input  logic                    pos_edge,
  input  logic                    neg_edge,
  output logic                    go,
  output logic                    last_clk,
  output logic                    mosi,
  input  logic                    miso,
  output logic [C_DATA_WIDTH-1:0] rx_data,
  output logic                    rx_valid,
  output logic                    busy
);

  typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

  state_t                  state;
  logic [C_DATA_WIDTH-1:0] tx_r;
  logic [C_DATA_WIDTH-1:0] rx_sr;
  logic [C_DATA_WIDTH-1:0] rx_next;
  logic                    cpol_r;
  logic                    cpha_r;
  logic                    lsb_r;
  logic [C_LEN_WIDTH-1:0]  len_r;
  logic [C_LEN_WIDTH-1:0]  cnt;
  logic [C_LEN_WIDTH-1:0]  cnt_inc;
  logic [C_LEN_WIDTH-1:0]  idx_cur;
  logic [C_LEN_WIDTH-1:0]  idx_nxt;
  logic [C_LEN_WIDTH-1:0]  first_idx;
  logic                    lead;
  logic                    trail;
  logic                    sample;
  logic                    at_last;

  always_comb begin
    lead      = cpol_r ? neg_edge : pos_edge;
    // A trail strobe coinciding with a lead strobe is dropped.
    trail     = (cpol_r ? pos_edge : neg_edge) && !lead;
    cnt_inc   = cnt + C_LEN_WIDTH'(1);
    // Bit position of the counter's current/next bit in the shift registers.
    idx_cur   = lsb_r ? cnt : len_r - cnt;
    idx_nxt   = lsb_r ? cnt_inc : len_r - cnt_inc;
    first_idx = lsb_first ? '0 : char_len;
    at_last   = (cnt == len_r);
    sample    = (state == XFER) && (cpha_r ? trail : lead);
    rx_next   = rx_sr;
    if (sample) begin
      rx_next[idx_cur] = miso;
    end
  end

  assign tx_ready = rst_n && enable && (state == IDLE);
  assign last_clk = enable && (state == XFER) && at_last;

  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      state    <= IDLE;
      tx_r     <= '0;
      rx_sr    <= '0;
      rx_data  <= '0;
      cpol_r   <= 1'b0;
      cpha_r   <= 1'b0;
      lsb_r    <= 1'b0;
      len_r    <= '0;
      cnt      <= '0;
      go       <= 1'b0;
      busy     <= 1'b0;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
    end else if (!enable) begin
      state    <= IDLE;
      go       <= 1'b0;
      busy     <= 1'b0;
      mosi     <= 1'b0;
      rx_valid <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (tx_valid) begin
            state  <= XFER;
            tx_r   <= tx_data;
            cpol_r <= CPOL;
            cpha_r <= CPHA;
            lsb_r  <= lsb_first;
            len_r  <= char_len;
            cnt    <= '0;
            rx_sr  <= '0;
            go     <= 1'b1;
            busy   <= 1'b1;
            // CPHA=0 presents the first bit before the first edge.
            mosi   <= CPHA ? 1'b0 : tx_data[first_idx];
          end
        end
        XFER: begin
          rx_sr <= rx_next;
          if (lead) begin
            if (cpha_r) begin
              mosi <= tx_r[idx_cur];
            end
          end else if (trail) begin
            if (at_last) begin
              state    <= DONE;
              go       <= 1'b0;
              busy     <= 1'b0;
              mosi     <= 1'b0;
              // Include the bit sampled on this final trail (CPHA=1).
              rx_data  <= rx_next;
              rx_valid <= 1'b1;
            end else begin
              cnt <= cnt_inc;
              if (!cpha_r) begin
                mosi <= tx_r[idx_nxt];
              end
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_shift_ctrl.sv
// tb_spi_shift_ctrl: self-checking bench for spi_shift_ctrl.
// A table of transfer vectors is applied in a loop; received words are
// checked through a scoreboard queue filled at accept and drained on
// rx_valid. Hand-written sequences cover reset, gating, idle strobes,
// abort, simultaneous strobes and reset mid-transfer.
module tb_spi_shift_ctrl;

  logic        sysclk;
  logic        rst_n;
  logic        enable;
  logic        cpol;
  logic        cpha;
  logic        lsb_first;
  logic [4:0]  char_len;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        pos_edge;
  logic        neg_edge;
  logic        go;
  logic        last_clk;
  logic        mosi;
  logic        miso;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        busy;

  logic        loop_en;
  logic        miso_val;

  assign miso = loop_en ? mosi : miso_val;

  spi_shift_ctrl #(
    .C_DATA_WIDTH (32),
    .C_LEN_WIDTH  (5)
  ) dut (
    .sysclk    (sysclk),
    .rst_n     (rst_n),
    .enable    (enable),
    .CPOL      (cpol),
    .CPHA      (cpha),
    .lsb_first (lsb_first),
    .char_len  (char_len),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .pos_edge  (pos_edge),
    .neg_edge  (neg_edge),
    .go        (go),
    .last_clk  (last_clk),
    .mosi      (mosi),
    .miso      (miso),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .busy      (busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    logic        cpol;
    logic        cpha;
    logic        lsb;
    logic [4:0]  len;
    logic [31:0] data;
    logic        loop;
    logic        miso_v;
    logic [31:0] exp_rx;
  } vec_t;

  int          total;
  int          bad;
  int          n_push;
  int          n_rx;
  logic [31:0] sb[$];
  logic        prev_rv;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard drain on every rx_valid pulse.
  initial prev_rv = 1'b0;
  always @(negedge sysclk) begin
    if (rx_valid === 1'b1) begin
      n_rx++;
      chk("rx_valid_width", {63'd0, prev_rv}, 64'd0);
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rx_unexpected: got rx_valid with rx_data %0h, expected none", rx_data);
      end else begin
        chk("rx_data", {32'd0, rx_data}, {32'd0, sb.pop_front()});
      end
    end
    prev_rv <= (rx_valid === 1'b1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Called just after a rising edge; drives strobes for one cycle and
  // samples mosi/last_clk mid-cycle.
  task automatic cycle_strobe(input logic pe, input logic ne, output logic ms, output logic ls);
    pos_edge = pe;
    neg_edge = ne;
    @(negedge sysclk);
    ms = mosi;
    ls = last_clk;
    @(posedge sysclk);
    #1;
    pos_edge = 1'b0;
    neg_edge = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_accept(input vec_t v, input bit push);
    logic got;
    cpol      = v.cpol;
    cpha      = v.cpha;
    lsb_first = v.lsb;
    char_len  = v.len;
    tx_data   = v.data;
    loop_en   = v.loop;
    miso_val  = v.miso_v;
    tx_valid  = 1'b1;
    got = 1'b0;
    for (int w = 0; w < 20 && !got; w++) begin
      @(negedge sysclk);
      got = tx_ready;
      @(posedge sysclk);
      #1;
    end
    chk("accept", {63'd0, got}, 64'd1);
    tx_valid = 1'b0;
    if (push) begin
      sb.push_back(v.exp_rx);
      n_push++;
    end
    // Configuration changes after accept must not affect the transfer.
    tx_data   = ~tx_data;
    char_len  = ~char_len;
    lsb_first = ~lsb_first;
    cpha      = ~cpha;
    cpol      = ~cpol;
    @(negedge sysclk);
    chk("go_busy_after_accept", {62'd0, go, busy}, 64'd3);
    @(posedge sysclk);
    #1;
  endtask

  task automatic do_bits(input vec_t v, input int nbits, input bit both,
                         output logic [31:0] mobs, output logic [63:0] lobs);
    logic ms;
    logic ls;
    logic lpe;
    logic lne;
    mobs = '0;
    lobs = '0;
    lpe = v.cpol ? both : 1'b1;
    lne = v.cpol ? 1'b1 : both;
    for (int i = 0; i < nbits; i++) begin
      cycle_strobe(lpe, lne, ms, ls);
      if (!v.cpha) mobs[i] = ms;
      lobs[2*i] = ls;
      idle_cycle();
      cycle_strobe(v.cpol, !v.cpol, ms, ls);
      if (v.cpha) mobs[i] = ms;
      lobs[2*i+1] = ls;
      if (i != int'(v.len)) idle_cycle();
    end
  endtask

  task automatic run_vec(input vec_t v, input bit both, input string tag);
    logic [31:0] mobs;
    logic [63:0] lobs;
    logic [31:0] em;
    logic [63:0] el;
    logic [31:0] d;
    int          idx;
    d  = v.data;
    em = '0;
    for (int i = 0; i <= int'(v.len); i++) begin
      idx   = v.lsb ? i : int'(v.len) - i;
      em[i] = d[idx];
    end
    el = 64'd3 << (2 * int'(v.len));
    do_accept(v, 1'b1);
    do_bits(v, int'(v.len) + 1, both, mobs, lobs);
    chk({tag, "_mosi_seq"}, {32'd0, mobs}, {32'd0, em});
    chk({tag, "_last_clk"}, lobs, el);
    @(negedge sysclk);
    chk({tag, "_done_go_busy_mosi"}, {61'd0, go, busy, mosi}, 64'd0);
    @(posedge sysclk);
    #1;
    @(negedge sysclk);
    chk({tag, "_tx_ready_after"}, {63'd0, tx_ready}, 64'd1);
    @(posedge sysclk);
    #1;
  endtask

  vec_t        tbl[8];
  vec_t        v;
  logic        acc;
  logic [31:0] mobs;
  logic [63:0] lobs;
  logic [31:0] last_rx;

  initial begin
    //          cpol  cpha  lsb   len    data           loop  miso  exp_rx
    tbl[0] = '{1'b0, 1'b0, 1'b0, 5'd7,  32'h000000A5, 1'b1, 1'b0, 32'h000000A5};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 5'd3,  32'h00000006, 1'b0, 1'b1, 32'h0000000F};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 5'd31, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 1'b0, 5'd15, 32'hFFFF1234, 1'b1, 1'b0, 32'h00001234};
    tbl[4] = '{1'b1, 1'b0, 1'b1, 5'd0,  32'h00000003, 1'b1, 1'b0, 32'h00000001};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 5'd11, 32'h0000FABC, 1'b0, 1'b0, 32'h00000000};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 5'd4,  32'h00000015, 1'b0, 1'b1, 32'h0000001F};
    tbl[7] = '{1'b1, 1'b0, 1'b0, 5'd9,  32'h000002C3, 1'b1, 1'b0, 32'h000002C3};

    total = 0; bad = 0; n_push = 0; n_rx = 0;
    rst_n = 1'b0; enable = 1'b1; cpol = 1'b0; cpha = 1'b0; lsb_first = 1'b0;
    char_len = '0; tx_data = '0; tx_valid = 1'b0; pos_edge = 1'b0; neg_edge = 1'b0;
    loop_en = 1'b0; miso_val = 1'b0;

    // Reset state: every output 0, tx_ready held low even with enable high.
    repeat (2) @(posedge sysclk);
    @(negedge sysclk);
    chk("reset_outputs", {25'd0, go, last_clk, mosi, rx_valid, busy, tx_ready, rx_data},
        64'd0);
    @(posedge sysclk);
    #1;
    rst_n = 1'b1;

    // Gating: enable low blocks acceptance.
    enable = 1'b0;
    tx_valid = 1'b1;
    acc = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge sysclk);
      acc = acc | tx_ready | go | busy;
      @(posedge sysclk);
      #1;
    end
    chk("gated_ready_go", {63'd0, acc}, 64'd0);
    tx_valid = 1'b0;
    enable = 1'b1;

    // Strobes while idle leave mosi and the bit counter untouched.
    acc = 1'b0;
    for (int c = 0; c < 4; c++) begin
      pos_edge = c[0];
      neg_edge = ~c[0];
      @(negedge sysclk);
      acc = acc | mosi | go | busy;
      @(posedge sysclk);
      #1;
    end
    pos_edge = 1'b0;
    neg_edge = 1'b0;
    @(negedge sysclk);
    acc = acc | mosi;
    chk("idle_strobes_mosi", {63'd0, acc}, 64'd0);
    @(posedge sysclk);
    #1;

    for (int t = 0; t < 8; t++) begin
      run_vec(tbl[t], 1'b0, $sformatf("vec%0d", t));
      last_rx = tbl[t].exp_rx;
    end

    // Abort after 3 trail strobes.
    v = '{1'b0, 1'b0, 1'b0, 5'd7, 32'h0000005A, 1'b1, 1'b0, 32'h0};
    do_accept(v, 1'b0);
    do_bits(v, 3, 1'b0, mobs, lobs);
    enable = 1'b0;
    @(posedge sysclk);
    #1;
    @(negedge sysclk);
    chk("abort_go_busy_mosi", {61'd0, go, busy, mosi}, 64'd0);
    @(posedge sysclk);
    #1;
    enable = 1'b1;
    repeat (3) idle_cycle();
    @(negedge sysclk);
    chk("abort_rx_data_kept", {32'd0, rx_data}, {32'd0, last_rx});
    @(posedge sysclk);
    #1;

    // Follow-on transfer, lead strobes doubled up with trail strobes.
    v = '{1'b0, 1'b0, 1'b0, 5'd7, 32'h0000003C, 1'b1, 1'b0, 32'h0000003C};
    run_vec(v, 1'b1, "post_abort");
    v = '{1'b1, 1'b1, 1'b1, 5'd5, 32'h00000029, 1'b1, 1'b0, 32'h00000029};
    run_vec(v, 1'b1, "both_strobes_m3");

    // Reset mid-transfer after bit 4.
    v = '{1'b0, 1'b0, 1'b0, 5'd7, 32'h000000FF, 1'b1, 1'b0, 32'h0};
    do_accept(v, 1'b0);
    do_bits(v, 4, 1'b0, mobs, lobs);
    rst_n = 1'b0;
    @(posedge sysclk);
    #1;
    @(negedge sysclk);
    chk("midreset_outputs", {25'd0, go, last_clk, mosi, rx_valid, busy, tx_ready, rx_data},
        64'd0);
    @(posedge sysclk);
    #1;
    rst_n = 1'b1;
    @(negedge sysclk);
    chk("midreset_idle", {62'd0, tx_ready, go}, 64'd2);
    @(posedge sysclk);
    #1;

    v = '{1'b0, 1'b1, 1'b1, 5'd6, 32'h00000055, 1'b1, 1'b0, 32'h00000055};
    run_vec(v, 1'b0, "post_reset");

    repeat (3) idle_cycle();
    chk("scoreboard_empty", 64'(sb.size()), 64'd0);
    chk("rx_count", 64'(n_rx), 64'(n_push));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_shift_ctrl.md
# spi_shift_ctrl

Transfer controller for the SPI master datapath, sitting directly in front of `spi_clk_gen`. It accepts a parallel word over a valid/ready handshake and drives `go` and `last_clk` into the clock generator. It consumes the generator's `pos_edge`/`neg_edge` strobes to shift MOSI out and sample MISO in, in any CPOL/CPHA mode, MSB- or LSB-first, for 1..C_DATA_WIDTH bits. It returns the received word with a one-cycle valid pulse.

## Interface
- C_DATA_WIDTH, 32: maximum character length in bits; shift register width.
- C_LEN_WIDTH, 5: width of `char_len`; must equal clog2(C_DATA_WIDTH).

- sysclk  in  1  system clock; all logic on its rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- enable  in  1  block enable; low aborts any transfer.
- CPOL  in  1  clock polarity; must match the value given to the clock generator.
- CPHA  in  1  clock phase: 0 = sample on leading edge, 1 = drive on leading edge.
- lsb_first  in  1  1 = bit 0 first, 0 = bit `char_len` first.
- char_len  in  C_LEN_WIDTH  bits per transfer minus 1.
- tx_data  in  C_DATA_WIDTH  word to send, right-aligned.
- tx_valid  in  1  `tx_data` valid.
- tx_ready  out  1  block can accept a word.
- pos_edge  in  1  one-cycle strobe: SCK rising edge.
- neg_edge  in  1  one-cycle strobe: SCK falling edge.
- go  out  1  run request to the clock generator.
- last_clk  out  1  final bit in progress.
- mosi  out  1  serial data out.
- miso  in  1  serial data in.
- rx_data  out  C_DATA_WIDTH  received word, right-aligned; bits above `char_len` are 0.
- rx_valid  out  1  one-cycle pulse: `rx_data` updated.
- busy  out  1  transfer in progress.

## Operation
- **Edge mapping.** `lead = CPOL ? neg_edge : pos_edge`; `trail` is the other strobe. Both use the CPOL value latched at accept.
- **IDLE.**
  - `tx_ready = enable`.
  - On `tx_valid && tx_ready`, latch `tx_data`, CPOL, CPHA, `lsb_first` and `char_len`, clear the bit counter, then go to XFER.
  - Strobes are ignored.
- **XFER.**
  - `go = 1`, `busy = 1`, `tx_ready = 0`.
  - CPHA=0:
    - `mosi` = first bit from the entry cycle.
    - Sample `miso` on each `lead`.
    - On each `trail`, advance `mosi` to the next bit and increment the counter.
  - CPHA=1:
    - On each `lead`, drive the next bit, with the first bit on the first `lead`.
    - Sample `miso` on each `trail`, then increment the counter.
  - Ending: when `trail` occurs with counter == `char_len`, go to DONE. The transfer always spans `char_len`+1 leading and `char_len`+1 trailing edges.
  - `last_clk` = XFER && counter == `char_len`.
- **DONE** (one cycle).
  - `go = 0`, `busy = 0`, `mosi = 0`.
  - `rx_data` is loaded from the receive shift register.
  - `rx_valid = 1`.
  - Next state is IDLE.
- **Bit order.**
  - MSB-first: transmit `tx_data[char_len]` down to bit 0. The first received bit lands in `rx_data[char_len]`.
  - LSB-first: transmit bit 0 up to bit `char_len`. The first received bit lands in bit 0.
  - Bits of `tx_data` above `char_len` are ignored.
- **Abort.** `enable` low in any state means next state IDLE.
  - `go`, `last_clk`, `busy` and `mosi` are 0.
  - No `rx_valid`; `rx_data` is retained.
- **Simultaneous strobes.** If `pos_edge` and `neg_edge` are high in the same cycle, only the `lead` action is taken and `trail` is ignored.
- **Configuration changes.** Changes to the configuration inputs during XFER have no effect until the next accept.

## Timing
- **Reset** (`rst_n` low at a sysclk edge): next state IDLE. Every output is 0: `go`, `last_clk`, `mosi`, `rx_data`, `rx_valid`, `busy`, `tx_ready`. This applies mid-transfer too. `tx_ready` stays 0 while `rst_n` is low.
- **Accept.** Accept occurs at edge T. `go`, `busy` and the first `mosi` bit (CPHA=0) are valid from T+1.
- **Strobe response.** A strobe high in cycle k updates `mosi` and the counter at the end of cycle k, so the effect is visible in k+1.
- **Completion.** The final `trail` arrives in cycle k. In k+1: DONE, `go` drops, `rx_valid` pulses and `rx_data` is valid. `tx_ready` rises in k+2.
- **Back-to-back.** Minimum gap is 2 cycles between the final `trail` and the next accept.
- **Outputs.** All outputs are registered except `tx_ready` and `last_clk`. These two are decoded from state registers and `enable` only; there is no combinational path from `tx_valid`.

## Test plan
- **Mode 0, MSB-first, 8 bits, loopback.** CPOL=0, CPHA=0, `char_len`=7, `tx_data`=0xA5, `miso` tied to `mosi`. Required:
  - `mosi` sequence 1,0,1,0,0,1,0,1.
  - 8 `pos_edge` and 8 `neg_edge` strobes consumed.
  - `rx_data`=0x000000A5.
  - `rx_valid` high for exactly 1 cycle.
- **Mode 3, LSB-first, 4 bits.** CPOL=1, CPHA=1, `lsb_first`=1, `char_len`=3, `tx_data`=0x6, `miso`=1. Required:
  - `mosi` updates on `neg_edge` with sequence 0,1,1,0.
  - `rx_data`=0x0000000F.
- **Full width.** `char_len`=31, `tx_data`=0xDEADBEEF, loopback. Required:
  - `rx_data`=0xDEADBEEF.
  - `last_clk` high only from the 31st `trail` until the 32nd.
- **Abort.** Drop `enable` after 3 `trail` strobes. Required:
  - `go`=0 and `busy`=0 next cycle.
  - No `rx_valid`; `rx_data` unchanged.
  - A following 0x3C transfer completes with `rx_data`=0x3C.
- **Gating and idle strobes.** `enable`=0 with `tx_valid`=1: `tx_ready`=0 and `go` stays 0. Strobes while IDLE: `mosi` and counter unchanged.
- **Reset mid-transfer.** Assert `rst_n`=0 after bit 4 of an 8-bit transfer. Required: all outputs 0 at the following edge, and the state is IDLE.
